patient_countdown_timer: RTL

- Consumer end of the control interface: takes the 4-bit state code and 24-bit BCD preset time (HH MM SS) from the control block and runs the medication/patient countdown.
- Counts down once per second, stops at 00:00:00 and raises an alarm.
- Returns the live count as 24-bit BCD; this feeds the control block's current-time input and the seven-segment display path.

---
 rtl/patient_countdown_timer_pkg.sv | 73 +++++++
 rtl/patient_countdown_timer_bcd_digit_down.sv | 36 +++
 rtl/patient_countdown_timer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/patient_countdown_timer_pkg.sv
// -----------------------------------------------------------------------------
// patient_countdown_timer_pkg
// Shared definitions for the patient countdown timer:
//   - control state codes driven by the control block
//   - BCD time packing (HH:MM:SS, six 4-bit digits)
//   - internal FSM encoding
//   - preset sanitising helpers
// -----------------------------------------------------------------------------
package patient_countdown_timer_pkg;

    // Control state codes from the control block; anything else is an exception.
    localparam logic [3:0] ST_RESET = 4'd0;
    localparam logic [3:0] ST_SET   = 4'd1;
    localparam logic [3:0] ST_LOAD  = 4'd2;
    localparam logic [3:0] ST_START = 4'd3;

    // Digit field offsets inside the 24-bit BCD word.
    localparam int unsigned HH_T_LSB = 20;
    localparam int unsigned HH_U_LSB = 16;
    localparam int unsigned MM_T_LSB = 12;
    localparam int unsigned MM_U_LSB = 8;
    localparam int unsigned SS_T_LSB = 4;
    localparam int unsigned SS_U_LSB = 0;

    typedef struct packed {
        logic [3:0] hh_t;
        logic [3:0] hh_u;
        logic [3:0] mm_t;
        logic [3:0] mm_u;
        logic [3:0] ss_t;
        logic [3:0] ss_u;
    } bcd_time_t;

    localparam bcd_time_t RESET_TIME = 24'h125959;
    localparam bcd_time_t ZERO_TIME  = 24'h000000;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_HOLD = 2'd1,
        FSM_RUN  = 2'd2,
        FSM_DONE = 2'd3
    } fsm_t;

    // Saturate a single digit to a ceiling.
    function automatic logic [3:0] digit_clamp(input logic [3:0] d, input logic [3:0] ceil);
        logic [3:0] r;
        if (d > ceil) begin
            r = ceil;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Force a raw preset into a legal duration (max 12:59:59, 00 hours allowed).
    function automatic bcd_time_t sanitise_time(input logic [23:0] raw);
        bcd_time_t t;
        t      = bcd_time_t'(raw);
        t.hh_t = digit_clamp(t.hh_t, 4'd1);
        t.hh_u = digit_clamp(t.hh_u, 4'd9);
        t.mm_t = digit_clamp(t.mm_t, 4'd5);
        t.mm_u = digit_clamp(t.mm_u, 4'd9);
        t.ss_t = digit_clamp(t.ss_t, 4'd5);
        t.ss_u = digit_clamp(t.ss_u, 4'd9);
        if (t.hh_t == 4'd1) begin
            t.hh_u = digit_clamp(t.hh_u, 4'd2);
        end else begin
            t.hh_u = t.hh_u;
        end
        return t;
    endfunction

endpackage

// File: rtl/patient_countdown_timer_bcd_digit_down.sv
// -----------------------------------------------------------------------------
// bcd_digit_down
// One BCD digit of the decrement borrow chain.
//   digit      : current digit value
//   borrow_in  : request to subtract one from this digit
//   digit_next : resulting digit (wraps 0 -> MAX)
//   borrow_out : propagated borrow when this digit wrapped
// -----------------------------------------------------------------------------
module bcd_digit_down #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] digit_next,
    output logic       borrow_out
);

    // Subtract the incoming borrow, wrapping to MAX and borrowing onward at zero.
    always_comb begin
        digit_next = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                digit_next = MAX;
                borrow_out = 1'b1;
            end else begin
                digit_next = digit - 4'd1;
                borrow_out = 1'b0;
            end
        end else begin
            digit_next = digit;
            borrow_out = 1'b0;
        end
    end

endmodule

// File: rtl/patient_countdown_timer.sv
// -----------------------------------------------------------------------------
// patient_countdown_timer
// Medication/patient countdown: loads a sanitised BCD preset, counts down once
// per second while started, stops at 00:00:00 and raises an alarm.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   state[3:0]         : control code 0 reset, 1 set, 2 load(hold), 3 start,
//                        4..15 exception (everything frozen)
//   preset_time[23:0]  : BCD HH MM SS preset
//   current_time[23:0] : live BCD count
//   running            : counting in progress
//   expired            : one-cycle pulse when a decrement reaches 00:00:00
//   alarm              : alarm indicator
//   tick               : one-cycle pulse on each internal second boundary
// Build option: PATIENT_TIMER_ALARM_BLINK_EN makes alarm toggle on every tick
// while expired (0.5 Hz blink); otherwise alarm is steady and the prescaler
// rests at zero once expired.
// -----------------------------------------------------------------------------
module patient_countdown_timer
    import patient_countdown_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned CNT_W    = 26
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  state,
    input  logic [23:0] preset_time,
    output logic [23:0] current_time,
    output logic        running,
    output logic        expired,
    output logic        alarm,
    output logic        tick
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    fsm_t             fsm_q, fsm_d;
    bcd_time_t        time_q, time_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             running_q, running_d;
    logic             expired_q, expired_d;
    logic             alarm_q, alarm_d;
    logic             tick_q, tick_d;

    bcd_time_t        dec_time_s;
    logic [5:0]       borrow_s;
    logic             wrap_s;
    logic             dec_zero_s;

    // Borrow chain: SS units always receives the one-second borrow.
    bcd_digit_down #(.MAX(4'd9)) u_ss_u (.digit(time_q.ss_u), .borrow_in(1'b1),
        .digit_next(dec_time_s.ss_u), .borrow_out(borrow_s[0]));
    bcd_digit_down #(.MAX(4'd5)) u_ss_t (.digit(time_q.ss_t), .borrow_in(borrow_s[0]),
        .digit_next(dec_time_s.ss_t), .borrow_out(borrow_s[1]));
    bcd_digit_down #(.MAX(4'd9)) u_mm_u (.digit(time_q.mm_u), .borrow_in(borrow_s[1]),
        .digit_next(dec_time_s.mm_u), .borrow_out(borrow_s[2]));
    bcd_digit_down #(.MAX(4'd5)) u_mm_t (.digit(time_q.mm_t), .borrow_in(borrow_s[2]),
        .digit_next(dec_time_s.mm_t), .borrow_out(borrow_s[3]));
    bcd_digit_down #(.MAX(4'd9)) u_hh_u (.digit(time_q.hh_u), .borrow_in(borrow_s[3]),
        .digit_next(dec_time_s.hh_u), .borrow_out(borrow_s[4]));
    bcd_digit_down #(.MAX(4'd9)) u_hh_t (.digit(time_q.hh_t), .borrow_in(borrow_s[4]),
        .digit_next(dec_time_s.hh_t), .borrow_out(borrow_s[5]));

    // Borrow out of HH tens means the count underflowed (corrupted state):
    // treat it as having reached zero rather than wrapping to 99:59:59.
    always_comb begin
        dec_zero_s = (dec_time_s == ZERO_TIME) || borrow_s[5];
        wrap_s     = (presc_q == TICK_LAST);
    end

    // Next-state logic: control code selects the mode; exceptions freeze all state.
    always_comb begin
        fsm_d     = fsm_q;
        time_d    = time_q;
        presc_d   = presc_q;
        running_d = running_q;
        alarm_d   = alarm_q;
        expired_d = 1'b0;
        tick_d    = 1'b0;
        case (state)
            ST_RESET, ST_SET: begin
                fsm_d     = FSM_IDLE;
                time_d    = sanitise_time(preset_time);
                presc_d   = '0;
                alarm_d   = 1'b0;
                running_d = 1'b0;
            end
            ST_LOAD: begin
                fsm_d     = FSM_HOLD;
                running_d = 1'b0;
            end
            ST_START: begin
                if (fsm_q == FSM_DONE) begin
                    running_d = 1'b0;
`ifdef PATIENT_TIMER_ALARM_BLINK_EN
                    if (wrap_s) begin
                        presc_d = '0;
                        alarm_d = ~alarm_q;
                        tick_d  = 1'b1;
                    end else begin
                        presc_d = presc_q + CNT_W'(1);
                    end
`else
                    presc_d = '0;
                    alarm_d = 1'b1;
`endif
                end else if (time_q == ZERO_TIME) begin
                    // Started with nothing to count: alarm without an expiry pulse.
                    fsm_d     = FSM_DONE;
                    presc_d   = '0;
                    alarm_d   = 1'b1;
                    running_d = 1'b0;
                end else if (wrap_s) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (dec_zero_s) begin
                        time_d    = ZERO_TIME;
                        fsm_d     = FSM_DONE;
                        expired_d = 1'b1;
                        alarm_d   = 1'b1;
                        running_d = 1'b0;
                    end else begin
                        time_d    = dec_time_s;
                        fsm_d     = FSM_RUN;
                        running_d = 1'b1;
                    end
                end else begin
                    fsm_d     = FSM_RUN;
                    presc_d   = presc_q + CNT_W'(1);
                    running_d = 1'b1;
                end
            end
            default: begin
                fsm_d     = fsm_q;
                time_d    = time_q;
                presc_d   = presc_q;
                running_d = running_q;
                alarm_d   = alarm_q;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q     <= FSM_IDLE;
            time_q    <= RESET_TIME;
            presc_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            alarm_q   <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            time_q    <= time_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            expired_q <= expired_d;
            alarm_q   <= alarm_d;
            tick_q    <= tick_d;
        end
    end

    assign current_time = time_q;
    assign running      = running_q;
    assign expired      = expired_q;
    assign alarm        = alarm_q;
    assign tick         = tick_q;

endmodule
